// File: rtl/biu_dma_pkg.sv
// rtl/biu_dma_pkg.sv - shared state encoding and constants for the BIU DMA copy engine
package biu_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

  localparam int DEFAULT_ADDR_STEP = 4;

endpackage

// File: rtl/biu_master_if.sv
// rtl/biu_master_if.sv - single-outstanding BIU master bus with device and bus-side modports
interface biu_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rnw;
  logic                  en;
  logic                  data_valid;
  logic                  busy;

  modport device (
    output address, data_out, rnw, en,
    input  data_in, data_valid, busy
  );

  modport bus (
    input  address, data_out, rnw, en,
    output data_in, data_valid, busy
  );
endinterface

// File: rtl/biu_dma_addr_gen.sv
// rtl/biu_dma_addr_gen.sv - loadable address pointer with fixed-step wrapping increment
module biu_dma_addr_gen
  import biu_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_STEP  = DEFAULT_ADDR_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] ptr_next
);

  logic [ADDR_WIDTH-1:0] ptr;

  // ptr_next is exposed so the owner can register the bus address in the same edge
  always_comb begin
    ptr_next = ptr;
    if (load) begin
      ptr_next = load_addr;
    end else if (advance) begin
      ptr_next = ptr + ADDR_WIDTH'(ADDR_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/biu_dma_copy.sv
// rtl/biu_dma_copy.sv - block copy engine on the BIU master port; BIU_DMA_FILL_EN adds pattern fill
module biu_dma_copy
  import biu_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ADDR_STEP  = DEFAULT_ADDR_STEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
`ifdef BIU_DMA_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
`endif
  output logic                  active,
  output logic                  done,
  biu_master_if.device          biu
);

  state_t                state;
  state_t                state_next;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  en_q;
  logic                  rnw_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] address_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [ADDR_WIDTH-1:0] rd_next;
  logic [ADDR_WIDTH-1:0] wr_next;
  logic                  accept;
  logic                  load;
  logic                  advance;
  logic                  fill_start;
  logic                  fill_mode;
  logic [DATA_WIDTH-1:0] fill_word;

`ifdef BIU_DMA_FILL_EN
  assign fill_start = fill;
  assign fill_word  = fill_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_mode <= 1'b0;
    end else if (load) begin
      fill_mode <= fill;
    end
  end
`else
  assign fill_start = 1'b0;
  assign fill_word  = '0;
  assign fill_mode  = 1'b0;
`endif

  assign biu.en       = en_q;
  assign biu.rnw      = rnw_q;
  assign biu.address  = address_q;
  assign biu.data_out = data_q;

  biu_dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .ADDR_STEP(ADDR_STEP)) u_rd_ptr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (src_addr),
    .advance   (advance),
    .ptr_next  (rd_next)
  );

  biu_dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .ADDR_STEP(ADDR_STEP)) u_wr_ptr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (dst_addr),
    .advance   (advance),
    .ptr_next  (wr_next)
  );

  always_comb begin
    accept     = en_q && !biu.busy;
    load       = (state == IDLE) && start;
    advance    = (state == WR_REQ) && accept;
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)       state_next = DONE;
          else if (fill_start) state_next = WR_REQ;
          else                 state_next = RD_REQ;
        end
      end
      RD_REQ:  if (accept) state_next = RD_WAIT;
      RD_WAIT: if (biu.data_valid) state_next = WR_REQ;
      WR_REQ: begin
        if (accept) begin
          if (remaining == LEN_WIDTH'(1)) state_next = DONE;
          else if (fill_mode)             state_next = WR_REQ;
          else                            state_next = RD_REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so en rises on the edge that enters a request state
  always_comb begin
    data_next = data_q;
    if (load && fill_start) begin
      data_next = fill_word;
    end else if ((state == RD_WAIT) && biu.data_valid) begin
      data_next = biu.data_in;
    end
    address_next = address_q;
    if (state_next == RD_REQ) begin
      address_next = rd_next;
    end else if (state_next == WR_REQ) begin
      address_next = wr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      en_q      <= 1'b0;
      rnw_q     <= 1'b1;
      address_q <= '0;
      data_q    <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      en_q      <= (state_next == RD_REQ) || (state_next == WR_REQ);
      rnw_q     <= (state_next != WR_REQ);
      address_q <= address_next;
      data_q    <= data_next;
      active    <= state_next inside {RD_REQ, RD_WAIT, WR_REQ};
      done      <= (state_next == DONE);
      if (load) begin
        remaining <= len;
      end else if (advance) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_biu_dma_copy.sv
// tb/tb_biu_dma_copy.sv - directed table and randomized jobs checked against a transaction-level model
module tb_biu_dma_copy;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          busy;
    int          lat;
    bit          fill;
    logic [31:0] fdata;
    bit          poke;
    int          exp_cycles;
    int          exp_xfers;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
`ifdef BIU_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_data;
`endif
  logic          active;
  logic          done;

  biu_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  biu_dma_copy #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ADDR_STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
`ifdef BIU_DMA_FILL_EN
    .fill      (fill),
    .fill_data (fill_data),
`endif
    .active    (active),
    .done      (done),
    .biu       (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cfg_busy = 0;
  int          cfg_lat  = 1;
  bit          cfg_spur = 1'b0;
  int          stab_err = 0;
  xfer_t       log_q[$];
  xfer_t       exp_q[$];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rdata(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: busy for cfg_busy cycles per new request, read data cfg_lat cycles after accept
  initial begin : slave
    bit          req_seen;
    bit          spurred;
    bit          held;
    int          busy_cnt;
    int          dv_wait;
    logic [31:0] dv_addr;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    logic        p_rnw;
    req_seen = 0; spurred = 0; held = 0; busy_cnt = 0; dv_wait = 0;
    dv_addr = '0; p_addr = '0; p_data = '0; p_rnw = 1'b1;
    bus.busy = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0;
    forever begin
      @(negedge clk);
      if (held && (bus.en !== 1'b1 || bus.address !== p_addr || bus.rnw !== p_rnw || bus.data_out !== p_data))
        stab_err++;
      if (active !== 1'b1) spurred = 0;
      bus.data_valid = 1'b0;
      if (dv_wait > 0) begin
        dv_wait--;
        if (dv_wait == 0) begin
          bus.data_valid = 1'b1;
          bus.data_in = rdata(dv_addr);
        end
      end
      if (cfg_spur && !spurred && bus.en === 1'b1 && bus.rnw === 1'b0) begin
        bus.data_valid = 1'b1;
        bus.data_in = 32'hDEAD_BEEF;
        spurred = 1;
      end
      if (bus.en === 1'b1 && !req_seen) begin
        req_seen = 1;
        busy_cnt = cfg_busy;
      end
      if (bus.en === 1'b1 && busy_cnt > 0) begin
        bus.busy = 1'b1;
        busy_cnt--;
      end else begin
        bus.busy = 1'b0;
      end
      held = (bus.en === 1'b1) && bus.busy;
      p_addr = bus.address; p_data = bus.data_out; p_rnw = bus.rnw;
      if (bus.en === 1'b1 && !bus.busy) begin
        req_seen = 0;
        if (bus.rnw) begin
          log_q.push_back('{1'b0, bus.address, rdata(bus.address)});
          dv_wait = cfg_lat;
          dv_addr = bus.address;
        end else begin
          log_q.push_back('{1'b1, bus.address, bus.data_out});
        end
      end
    end
  end

  // Reference: the list of bus transfers a job must produce, and its completion time
  task automatic build_exp(input vec_t v);
    logic [31:0] sa;
    logic [31:0] da;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      sa = v.src + 32'(i * 4);
      da = v.dst + 32'(i * 4);
      if (v.fill) begin
        exp_q.push_back('{1'b1, da, v.fdata});
      end else begin
        exp_q.push_back('{1'b0, sa, rdata(sa)});
        exp_q.push_back('{1'b1, da, rdata(sa)});
      end
    end
  endtask

  function automatic int model_cycles(input vec_t v);
    if (v.len == 0) return 1;
    if (v.fill) return 1 + int'(v.len) * (v.busy + 1);
    return 1 + int'(v.len) * (2 * (v.busy + 1) + v.lat);
  endfunction

  function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                              input int b, input int l, input bit f, input logic [31:0] fd,
                              input bit p, input int ec, input int ex);
    vec_t v;
    v.src = s; v.dst = d; v.len = n; v.busy = b; v.lat = l; v.fill = f; v.fdata = fd;
    v.poke = p; v.exp_cycles = ec; v.exp_xfers = ex;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, ":en"},       64'(bus.en),       64'(0));
    chk({tag, ":rnw"},      64'(bus.rnw),      64'(1));
    chk({tag, ":address"},  64'(bus.address),  64'(0));
    chk({tag, ":data_out"}, 64'(bus.data_out), 64'(0));
    chk({tag, ":active"},   64'(active),       64'(0));
    chk({tag, ":done"},     64'(done),         64'(0));
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int cyc;
    int act_cnt;
    int first_en;
    int base;
    int stab0;
    bit seen_done;
    cfg_busy = v.busy; cfg_lat = v.lat; cfg_spur = v.poke;
    base = log_q.size();
    stab0 = stab_err;
    build_exp(v);
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len;
`ifdef BIU_DMA_FILL_EN
    fill = v.fill; fill_data = v.fdata;
`endif
    start = 1'b1;
    cyc = 0; act_cnt = 0; first_en = 0; seen_done = 0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = v.poke && (cyc == 2);
      if (start) begin
        src_addr = 32'h0BAD_0000; dst_addr = 32'h0BAD_1000; len = 16'd5;
      end
      if (active === 1'b1) act_cnt++;
      if (bus.en === 1'b1 && first_en == 0) first_en = cyc;
      if (done === 1'b1) seen_done = 1;
    end
    start = 1'b0;
    chk({tag, ":done_cycles"},   64'(cyc),      64'(v.exp_cycles));
    chk({tag, ":active_cycles"}, 64'(act_cnt),  64'(v.len == 0 ? 0 : v.exp_cycles - 1));
    chk({tag, ":first_en"},      64'(first_en), 64'(v.len == 0 ? 0 : 1));
    @(negedge clk);
    chk({tag, ":done_pulse"},    64'(done),     64'(0));
    chk({tag, ":idle_en"},       64'(bus.en),   64'(0));
    chk({tag, ":xfers"},         64'(log_q.size() - base), 64'(v.exp_xfers));
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      chk($sformatf("%s:x%0d_kind_addr", tag, i), {31'd0, log_q[base+i].wr, log_q[base+i].addr},
          {31'd0, exp_q[i].wr, exp_q[i].addr});
      chk($sformatf("%s:x%0d_data", tag, i), 64'(log_q[base+i].data), 64'(exp_q[i].data));
    end
    chk({tag, ":stable_under_busy"}, 64'(stab_err - stab0), 64'(0));
    if (!seen_done) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin : main
    vec_t tbl[$];
    vec_t v;
    int   cyc;
    int   base;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef BIU_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    tbl.push_back(mk(32'h100,      32'h200,      16'd3, 0, 1, 1'b0, 32'h0, 1'b0, 10, 6));
    tbl.push_back(mk(32'h300,      32'h400,      16'd2, 4, 1, 1'b0, 32'h0, 1'b0, 23, 4));
    tbl.push_back(mk(32'h700,      32'h800,      16'd0, 0, 1, 1'b0, 32'h0, 1'b0,  1, 0));
    tbl.push_back(mk(32'hFFFFFFFC, 32'h1000,     16'd2, 0, 1, 1'b0, 32'h0, 1'b1,  7, 4));
    tbl.push_back(mk(32'h20,       32'hFFFFFFF8, 16'd2, 1, 3, 1'b0, 32'h0, 1'b0, 15, 4));
    tbl.push_back(mk(32'h0,        32'h10,       16'd1, 0, 1, 1'b0, 32'h0, 1'b0,  4, 2));
`ifdef BIU_DMA_FILL_EN
    tbl.push_back(mk(32'h0,        32'h40,       16'd4, 0, 1, 1'b1, 32'h5A5A5A5A, 1'b0,  5, 4));
    tbl.push_back(mk(32'h0,        32'h80,       16'd3, 2, 1, 1'b1, 32'h12345678, 1'b1, 10, 3));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      run_job(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while a read is outstanding; the late data_valid must not be taken
    cfg_busy = 0; cfg_lat = 4; cfg_spur = 1'b0;
    base = log_q.size();
    @(negedge clk);
    src_addr = 32'h500; dst_addr = 32'h600; len = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (log_q.size() == base && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid:read_accepted", 64'(log_q.size() - base), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rstmid");
    repeat (6) @(negedge clk);
    chk("rstmid:late_en",       64'(bus.en),       64'(0));
    chk("rstmid:late_data_out", 64'(bus.data_out), 64'(0));
    chk("rstmid:late_active",   64'(active),       64'(0));
    chk("rstmid:no_more_xfers", 64'(log_q.size() - base), 64'(1));
    run_job(mk(32'h500, 32'h600, 16'd2, 0, 1, 1'b0, 32'h0, 1'b0, 7, 4), "after_rst");

    for (int n = 0; n < 25; n++) begin
      v.src   = $urandom;
      v.dst   = $urandom;
      v.len   = 16'($urandom_range(0, 6));
      v.busy  = int'($urandom_range(0, 3));
      v.lat   = int'($urandom_range(1, 3));
`ifdef BIU_DMA_FILL_EN
      v.fill  = 1'($urandom_range(0, 1));
`else
      v.fill  = 1'b0;
`endif
      v.fdata = $urandom;
      v.poke  = ($urandom_range(0, 3) == 0);
      v.exp_cycles = model_cycles(v);
      v.exp_xfers  = v.fill ? int'(v.len) : 2 * int'(v.len);
      run_job(v, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
